fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. Holds the program counter, presents the fetch address to instruction memory, and registers the returned word into the ID stage, where the instruction decoder consumes it. It also computes the next PC from redirect requests raised in ID (beq taken, j/jal, jr); branches use one architectural delay slot, so there is no flush. A stall input from the hazard unit freezes the PC and the IF/ID register.

## Interface
- `PC_RESET`, default 32'h0000_3000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard-unit request to freeze the PC and IF/ID this cycle.
- `branch_taken` in 1: ID holds a beq and its comparison, made on forwarded operands, is true.
- `jump` in 1: ID holds a j or jal (decoder `jump`).
- `jr_sel` in 1: ID holds a jr (decoder `jr_slt`).
- `jr_target` in 32: forwarded rs value for jr.
- `imem_rdata` in 32: instruction word at `imem_addr`, combinational read.
- `imem_addr` out 32: current PC.
- `ins_d` out 32: instruction in ID, which feeds the decoder.
- `pc_d` out 32: PC of `ins_d`.
- `pc8_d` out 32: `pc_d` + 8, the jal link value.
- `adel_d` out 1: `ins_d` was fetched from a PC whose bits [1:0] are non-zero.

## Operation
- **Next PC.**
  - `npc` is selected with priority jr > jump > branch > sequential.
  - jr: `jr_target`.
  - jump: {`pc_d`+4 [31:28], `ins_d`[25:0], 2'b00}.
  - branch: `pc_d` + 4 + (sign-extend(`ins_d`[15:0]) << 2), using 32-bit wrap-around arithmetic.
  - Otherwise: PC + 4, which also wraps modulo 2^32.
  - Redirect targets are computed from ID-stage registers (`ins_d`, `pc_d`), never from the instruction currently being fetched.
- **Update rule**, on each rising edge with `rst_n` high:
  - `stall`=0: PC ← `npc`; `ins_d` ← `imem_rdata`; `pc_d` ← PC; `adel_d` ← (PC[1:0] ≠ 0).
  - `stall`=1: PC, `ins_d`, `pc_d` and `adel_d` all hold.
  - `stall` overrides any redirect. Because the stalled ID instruction stays in place, its redirect is presented again on the cycle the stall drops and is honoured then.
- **Delay slot.** The instruction fetched in the same cycle that a redirect is active is the delay slot. It enters ID normally and is never squashed.
- **Misaligned PC.**
  - A jr to a non-word-aligned target is still loaded into the PC.
  - `imem_addr` exposes the full value; memory ignores bits [1:0].
  - `adel_d` flags the word when it reaches ID. No other action is taken here.
- **Mutually exclusive redirects.** Simultaneous `jump`/`jr_sel`/`branch_taken` cannot come from a legal decode. If they occur anyway, the priority above applies.

## Timing
- **Reset values.**
  - PC = `PC_RESET`, so `imem_addr` = `PC_RESET`.
  - `ins_d` = 32'h0000_0000, a nop (sll $0,$0,0).
  - `pc_d` = 32'h0000_0000, so `pc8_d` = 32'h0000_0008.
  - `adel_d` = 0.
- Reset is asynchronous: outputs take their reset values immediately on `rst_n` falling. A reset that arrives mid-stall or mid-redirect discards the pending state.
- The first edge after `rst_n` rises loads `ins_d` = mem[`PC_RESET`] and PC = `PC_RESET`+4.
- **Latency.** A word is visible on `ins_d` one cycle after its address appears on `imem_addr`. A redirect decided in ID cycle N sets `imem_addr` to the target in cycle N+1.
- `npc` and `pc8_d` are combinational from the registers and inputs. There is no combinational path from `imem_rdata` to any output.

## Structure
- Shared package `mips_pkg`:
  - `PC_RESET` default;
  - `NOP_WORD`;
  - opcode and funct constants, also used by the decoder;
  - a 2-bit `npc_sel_t` enum with values SEQ, BR, J, JR.
- One natural sub-module, `npc_unit`: combinational target computation and priority select. It contains the sign-extend, the shift and the 32-bit adders.
- `fetch_stage` holds the PC register, the IF/ID register and the stall gating.

## Test plan
- **Reset and sequential fetch.** Assert `rst_n`=0 mid-run → `imem_addr`=0x3000 and `ins_d`=0 immediately. Release with mem[0x3000]=0x3C01_1234 → after 1 edge, `ins_d`=0x3C01_1234, `pc_d`=0x3000, `pc8_d`=0x3008, `imem_addr`=0x3004.
- **Branch with delay slot.** beq at 0x3008 with imm=0xFFFE and `branch_taken`=1 → next `imem_addr`=0x3004. The word at 0x300C still appears on `ins_d`.
- **Jump and jal.** j with `ins_d`[25:0]=0x0000C10 at `pc_d`=0x3010 → `imem_addr`=0x0000_3040. jal gives `pc8_d`=0x3018.
- **jr.** `jr_sel`=1, `jr_target`=0x0000_3100 → `imem_addr`=0x3100.
- **Misaligned jr.** `jr_sel`=1, `jr_target`=0x3102 → the next `ins_d` has `adel_d`=1.
- **Stall versus redirect.**
  - `stall`=1 for 3 cycles with `jump`=1 → PC, `ins_d` and `pc_d` unchanged across all 3 edges.
  - Drop `stall` → the jump target is loaded on the next edge.
  - A PC of 0xFFFF_FFFC increments to 0x0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants and types for the five-stage MIPS core.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // Primary opcodes (ins[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (ins[5:0])
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    J   = 2'd2,
    JR  = 2'd3
  } npc_sel_t;

endpackage

`default_nettype wire

// File: rtl/npc_unit.sv
// ============================================================================
// Module   : npc_unit
// Purpose  : Next-PC target computation and jr > jump > branch > seq select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module npc_unit
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_d,
  input  logic [25:0] instr_index,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr_sel,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic [31:0] pc8_d
);

  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_d4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  npc_sel_t    w_sel;

  assign w_pc_seq    = pc + 32'd4;
  assign w_pc_d4     = pc_d + 32'd4;
  assign pc8_d       = pc_d + 32'd8;
  assign w_br_offset = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};
  assign w_br_target = w_pc_d4 + w_br_offset;
  assign w_j_target  = {w_pc_d4[31:28], instr_index, 2'b00};

  // Illegal multi-redirect combinations resolve by this fixed priority.
  always_comb begin
    w_sel = SEQ;
    if (jr_sel)            w_sel = JR;
    else if (jump)         w_sel = J;
    else if (branch_taken) w_sel = BR;
  end

  always_comb begin
    npc = w_pc_seq;
    case (w_sel)
      JR:      npc = jr_target;
      J:       npc = w_j_target;
      BR:      npc = w_br_target;
      default: npc = w_pc_seq;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC register, instruction fetch and IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr_sel,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] ins_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        adel_d
);

  logic [31:0] r_pc;
  logic [31:0] r_ins_d;
  logic [31:0] r_pc_d;
  logic        r_adel_d;
  logic [31:0] w_npc;

  // Targets come from the ID-stage registers, never from the word in fetch.
  npc_unit u_npc_unit (
    .pc           (r_pc),
    .pc_d         (r_pc_d),
    .instr_index  (r_ins_d[25:0]),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr_sel       (jr_sel),
    .jr_target    (jr_target),
    .npc          (w_npc),
    .pc8_d        (pc8_d)
  );

  // A stalled ID instruction keeps its redirect alive until the stall drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= PC_RESET;
      r_ins_d  <= NOP_WORD;
      r_pc_d   <= 32'h0000_0000;
      r_adel_d <= 1'b0;
    end else if (!stall) begin
      r_pc     <= w_npc;
      r_ins_d  <= imem_rdata;
      r_pc_d   <= r_pc;
      r_adel_d <= (r_pc[1:0] != 2'b00);
    end
  end

  assign imem_addr = r_pc;
  assign ins_d     = r_ins_d;
  assign pc_d      = r_pc_d;
  assign adel_d    = r_adel_d;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jr_sel;
  logic [31:0] jr_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] ins_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        adel_d;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(.PC_RESET(32'h0000_3000)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr_sel       (jr_sel),
    .jr_target    (jr_target),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .ins_d        (ins_d),
    .pc_d         (pc_d),
    .pc8_d        (pc8_d),
    .adel_d       (adel_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory: a few programmed words, otherwise {E0, addr[23:0]}.
  logic [31:0] w_word_addr;
  assign w_word_addr = {imem_addr[31:2], 2'b00};
  always_comb begin
    imem_rdata = {8'hE0, w_word_addr[23:0]};
    case (w_word_addr)
      32'h0000_3000: imem_rdata = 32'h3C01_1234;
      32'h0000_3008: imem_rdata = 32'h1000_FFFE;
      32'h0000_3010: imem_rdata = 32'h0800_0C10;
      default:       imem_rdata = {8'hE0, w_word_addr[23:0]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] e_addr, input logic [31:0] e_ins,
                          input logic [31:0] e_pc_d);
    check({tag, ".imem_addr"}, imem_addr, e_addr);
    check({tag, ".ins_d"}, ins_d, e_ins);
    check({tag, ".pc_d"}, pc_d, e_pc_d);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    jr_sel = 1'b0; jr_target = 32'h0;
    step(); step();
    check_if("rst0", 32'h3000, 32'h0, 32'h0);
    check("rst0.pc8_d", pc8_d, 32'h8);
    check("rst0.adel_d", {31'h0, adel_d}, 32'h0);
    rst_n = 1'b1;
    step(); step();
    check_if("pre", 32'h3008, 32'hE000_3004, 32'h3004);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("arst.imem_addr", imem_addr, 32'h3000);
    check("arst.ins_d", ins_d, 32'h0);
    #2 rst_n = 1'b1;
    step();
    check_if("seq1", 32'h3004, 32'h3C01_1234, 32'h3000);
    check("seq1.pc8_d", pc8_d, 32'h3008);
    step();
    step();
    check_if("beq_in_id", 32'h300C, 32'h1000_FFFE, 32'h3008);

    // Taken beq, imm -2: target 0x300C - 8 = 0x3004, delay slot 0x300C kept
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    check_if("beq", 32'h3004, 32'hE000_300C, 32'h300C);
    step(); step(); step(); step();
    check_if("j_in_id", 32'h3014, 32'h0800_0C10, 32'h3010);
    check("jal.pc8_d", pc8_d, 32'h3018);

    jump = 1'b1;
    step();
    jump = 1'b0;
    check_if("j", 32'h3040, 32'hE000_3014, 32'h3014);

    // All redirects at once: jr wins, target 0x3100
    jr_sel = 1'b1; jump = 1'b1; branch_taken = 1'b1; jr_target = 32'h3100;
    step();
    check_if("jr", 32'h3100, 32'hE000_3040, 32'h3040);

    jump = 1'b0; branch_taken = 1'b0; jr_target = 32'h3102;
    step();
    jr_sel = 1'b0;
    check_if("jr_mis", 32'h3102, 32'hE000_3100, 32'h3100);
    check("jr_mis.adel_d", {31'h0, adel_d}, 32'h0);
    step();
    check_if("adel", 32'h3106, 32'hE000_3100, 32'h3102);
    check("adel.adel_d", {31'h0, adel_d}, 32'h1);
    check("adel.pc8_d", pc8_d, 32'h310A);

    // jump beats branch: j -> 0xC400, branch would give 0xF506
    jump = 1'b1; branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    check_if("j_over_br", 32'hC400, 32'hE000_3104, 32'h3106);

    // Stall holds everything for 3 edges despite a pending jump (target 0xC410)
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_if("stall", 32'hC400, 32'hE000_3104, 32'h3106);
      check("stall.adel_d", {31'h0, adel_d}, 32'h1);
    end
    stall = 1'b0;
    step();
    jump = 1'b0;
    check_if("unstall", 32'hC410, 32'hE000_C400, 32'hC400);
    check("unstall.adel_d", {31'h0, adel_d}, 32'h0);

    // PC wrap-around
    jr_sel = 1'b1; jr_target = 32'hFFFF_FFFC;
    step();
    jr_sel = 1'b0;
    check("wrap0.imem_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check_if("wrap", 32'h0000_0000, 32'hE0FF_FFFC, 32'hFFFF_FFFC);
    check("wrap.pc8_d", pc8_d, 32'h0000_0004);

    // Reset while stalled with a pending jump discards everything
    stall = 1'b1; jump = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_if("rst_stall", 32'h3000, 32'h0, 32'h0);
    stall = 1'b0; jump = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check_if("rst_rel", 32'h3004, 32'h3C01_1234, 32'h3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
